// File: rtl/fc_requant_pack_if.sv
// Control, source-read and destination-write signals of the requant/pack stage.
// The slave modport is the stage itself; the master modport is its environment.
interface fc_requant_pack_if #(
    parameter int IN_DEPTH   = 128,
    parameter int PACK_LANES = 128
);
    localparam int SRC_AW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int DST_AW = 2;

    logic                    start;
    logic [4:0]              shift;
    logic                    busy;
    logic                    done;
    logic [SRC_AW-1:0]       src_addr;
    logic signed [31:0]      src_data;
    logic                    dst_wren;
    logic [DST_AW-1:0]       dst_addr;
    logic [8*PACK_LANES-1:0] dst_data;

    modport master (
        output start, shift, src_data,
        input  busy, done, src_addr, dst_wren, dst_addr, dst_data
    );

    modport slave (
        input  start, shift, src_data,
        output busy, done, src_addr, dst_wren, dst_addr, dst_data
    );
endinterface

// File: rtl/fc_requant_pack.sv
// Reads int32 FC results, shifts/saturates them to int8 and packs them lane-wise
// into wide words. Define FC_REQUANT_ROUND_EN for round-half-up before the shift.
module fc_requant_pack #(
    parameter int IN_DEPTH    = 128,
    parameter int PACK_LANES  = 128,
    parameter int RAM_LATENCY = 3
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    fc_requant_pack_if.slave  bus
);
    localparam int SRC_AW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int LANE_W = $clog2(PACK_LANES);
    localparam int DST_AW = 2;
    localparam logic [SRC_AW-1:0] LAST_IDX = SRC_AW'(IN_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [4:0]        shift_reg;
    logic [SRC_AW-1:0] addr_reg;
    logic [RAM_LATENCY-1:0] vld_pipe_reg;
    logic [SRC_AW-1:0] idx_pipe_reg [RAM_LATENCY];
    logic [7:0]        pack_reg [PACK_LANES];
    logic              wren_reg;
    logic              last_word_reg;
    logic [DST_AW-1:0] dst_addr_reg;

    logic              start_accept;
    logic              issue;
    logic              ret_vld;
    logic [SRC_AW-1:0] ret_idx;
    logic [LANE_W-1:0] ret_lane;
    logic              ret_word_end;
    logic signed [32:0] t_ext, t_rnd, y_shr;
    logic [7:0]        ret_byte;

    assign start_accept = (state_reg == S_IDLE) && bus.start;
    assign issue        = (state_reg == S_ISSUE);
    assign ret_vld      = vld_pipe_reg[RAM_LATENCY-1];
    assign ret_idx      = idx_pipe_reg[RAM_LATENCY-1];
    assign ret_lane     = ret_idx[LANE_W-1:0];
    assign ret_word_end = ret_vld && (ret_lane == {LANE_W{1'b1}});

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE:  if (bus.start) state_next = S_ISSUE;
            S_ISSUE: if (addr_reg == LAST_IDX) state_next = S_DRAIN;
            S_DRAIN: if (wren_reg && last_word_reg) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // The address counter holds on the final index once issuing stops.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shift_reg <= '0;
            addr_reg  <= '0;
        end else if (start_accept) begin
            shift_reg <= bus.shift;
            addr_reg  <= '0;
        end else if (issue && (addr_reg != LAST_IDX)) begin
            addr_reg  <= addr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_pipe_reg[0] <= 1'b0;
            idx_pipe_reg[0] <= '0;
        end else begin
            vld_pipe_reg[0] <= issue;
            idx_pipe_reg[0] <= addr_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < RAM_LATENCY; gi++) begin : g_pipe
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    vld_pipe_reg[gi] <= 1'b0;
                    idx_pipe_reg[gi] <= '0;
                end else begin
                    vld_pipe_reg[gi] <= vld_pipe_reg[gi-1];
                    idx_pipe_reg[gi] <= idx_pipe_reg[gi-1];
                end
            end
        end
    endgenerate

    // 33-bit working width keeps the rounding offset from wrapping at INT32_MAX.
    always_comb begin
        t_ext = {bus.src_data[31], bus.src_data};
`ifdef FC_REQUANT_ROUND_EN
        if (shift_reg != 5'd0) begin
            t_rnd = t_ext + (33'sd1 << (shift_reg - 5'd1));
        end else begin
            t_rnd = t_ext;
        end
`else
        t_rnd = t_ext;
`endif
        y_shr = t_rnd >>> shift_reg;
        if (y_shr > 33'sd127) begin
            ret_byte = 8'h7F;
        end else if (y_shr < -33'sd128) begin
            ret_byte = 8'h80;
        end else begin
            ret_byte = y_shr[7:0];
        end
    end

    generate
        for (gi = 0; gi < PACK_LANES; gi++) begin : g_lane
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    pack_reg[gi] <= '0;
                end else if (ret_vld && (ret_lane == LANE_W'(gi))) begin
                    pack_reg[gi] <= ret_byte;
                end
            end
            assign bus.dst_data[8*gi +: 8] = pack_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wren_reg      <= 1'b0;
            last_word_reg <= 1'b0;
            dst_addr_reg  <= '0;
        end else begin
            wren_reg      <= ret_word_end;
            last_word_reg <= ret_word_end && (ret_idx == LAST_IDX);
            if (ret_word_end) begin
                dst_addr_reg <= DST_AW'(ret_idx >> LANE_W);
            end
        end
    end

    assign bus.busy     = (state_reg != S_IDLE);
    assign bus.done     = (state_reg == S_DONE);
    assign bus.src_addr = addr_reg;
    assign bus.dst_wren = wren_reg;
    assign bus.dst_addr = dst_addr_reg;
endmodule
